// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
//   Groups the two requester ports and the memory-side bus of dmem_arbiter.
//
//   slave  modport : the arbiter's view. It takes the requests and the memory
//                    read data. It drives the grants, the read returns and the
//                    memory controls.
//   master modport : the surrounding system's view. This covers port A (the
//                    load/store unit), port B (the debug/DMA loader) and the
//                    memory's read-data return.
//
//   Signals per requester x in {a, b}:
//     x_req, x_wen, x_lock, x_addr[AW], x_wdata[DW]  -> arbiter
//     x_gnt, x_rvalid, x_rdata[DW]                   <- arbiter
//   Memory side:
//     mem_rst, mem_wen, mem_addr[AW], mem_wdata[DW]  <- arbiter
//     mem_rdata[DW] (valid the cycle after the addr) -> arbiter
// -----------------------------------------------------------------------------
`ifndef ISIZE
`define ISIZE 16
`endif
`ifndef DSIZE
`define DSIZE 16
`endif

interface dmem_arbiter_if #(
    parameter int AW = `ISIZE,
    parameter int DW = `DSIZE
);
    // port A
    logic          a_req;
    logic          a_wen;
    logic          a_lock;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata;
    logic          a_gnt;
    logic          a_rvalid;
    logic [DW-1:0] a_rdata;
    // port B
    logic          b_req;
    logic          b_wen;
    logic          b_lock;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata;
    logic          b_gnt;
    logic          b_rvalid;
    logic [DW-1:0] b_rdata;
    // memory
    logic          mem_rst;
    logic          mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  a_req, a_wen, a_lock, a_addr, a_wdata,
        input  b_req, b_wen, b_lock, b_addr, b_wdata,
        input  mem_rdata,
        output a_gnt, a_rvalid, a_rdata,
        output b_gnt, b_rvalid, b_rdata,
        output mem_rst, mem_wen, mem_addr, mem_wdata
    );

    modport master (
        output a_req, a_wen, a_lock, a_addr, a_wdata,
        output b_req, b_wen, b_lock, b_addr, b_wdata,
        output mem_rdata,
        input  a_gnt, a_rvalid, a_rdata,
        input  b_gnt, b_rvalid, b_rdata,
        input  mem_rst, mem_wen, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares one single-port data memory between port A (core load/store unit)
//   and port B (debug/DMA loader). The memory has a registered read address.
//   Its reset is active-high and synchronous, and that reset loads its image.
//
//   Arbitration is round-robin. A requester may assert x_lock to keep
//   ownership across beats. Ownership ends when the owner drops lock or req,
//   or after MAX_LOCK consecutive grants. The block also returns per-port
//   read-valid strobes. It holds the memory in reset for two clock edges after
//   rst is released.
//
//   Ports:
//     clk        clock
//     rst        asynchronous, active-low reset
//     bus        dmem_arbiter_if.slave (requester ports A/B + memory bus)
//   Optional (macro DMEM_ARB_STATS_EN):
//     clr_stats  clears both grant counters (wins over an increment)
//     a_cnt      saturating 16-bit count of grants to port A
//     b_cnt      saturating 16-bit count of grants to port B
// -----------------------------------------------------------------------------
`ifndef ISIZE
`define ISIZE 16
`endif
`ifndef DSIZE
`define DSIZE 16
`endif

module dmem_arbiter #(
    parameter int AW       = `ISIZE,
    parameter int DW       = `DSIZE,
    parameter int MAX_LOCK = 8          // 1..255
) (
    input  logic                clk,
    input  logic                rst,
    dmem_arbiter_if.slave       bus
`ifdef DMEM_ARB_STATS_EN
    ,
    input  logic                clr_stats,
    output logic [15:0]         a_cnt,
    output logic [15:0]         b_cnt
`endif
);

    // Arbiter states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_OWN_A = 2'd1;
    localparam logic [1:0] ST_OWN_B = 2'd2;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    // Number of post-reset edges during which the memory reset is held high
    localparam logic [1:0] INIT_EDGES = 2'd2;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]    r_state;
    logic          r_last;        // port granted most recently
    logic [7:0]    r_lock_cnt;    // consecutive grants under the current lock
    logic [1:0]    r_init_cnt;    // edges seen since rst released (saturates)
    logic [AW-1:0] r_mem_addr;    // address held when no grant
    logic [DW-1:0] r_mem_wdata;   // write data held when no grant
    logic          r_rv_valid;    // a read was granted last cycle
    logic          r_rv_port;     // ... and this is its port
    logic [DW-1:0] r_a_rdata;     // last data returned to A
    logic [DW-1:0] r_b_rdata;     // last data returned to B

    // ------------------------------------------------------------------
    // Wires
    // ------------------------------------------------------------------
    logic          w_mem_rst;
    logic          w_a_gnt;
    logic          w_b_gnt;
    logic          w_gnt;
    logic          w_gnt_port;
    logic          w_gnt_wen;
    logic          w_gnt_lock;
    logic [AW-1:0] w_gnt_addr;
    logic [DW-1:0] w_gnt_wdata;
    logic          w_owner;       // owner port when in an OWN state
    logic          w_owner_req;
    logic          w_owner_lock;
    logic          w_a_rvalid;
    logic          w_b_rvalid;
    logic [1:0]    w_state_nxt;
    logic          w_last_nxt;
    logic [7:0]    w_lock_cnt_nxt;

    // The memory stays in reset until two edges after rst is released.
    // All grants are suppressed during that time.
    assign w_mem_rst = (r_init_cnt != INIT_EDGES);

    // ------------------------------------------------------------------
    // Grant selection
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of an always_comb gets a default first; a path
        // that leaves a signal unassigned would otherwise infer a latch.
        w_a_gnt = 1'b0;
        w_b_gnt = 1'b0;
        if (!w_mem_rst) begin
            case (r_state)
                ST_OWN_A: w_a_gnt = bus.a_req;
                ST_OWN_B: w_b_gnt = bus.b_req;
                default: begin
                    if (bus.a_req && bus.b_req) begin
                        // Tie: the port that was not served last wins
                        if (r_last == PORT_B) w_a_gnt = 1'b1;
                        else                  w_b_gnt = 1'b1;
                    end else begin
                        w_a_gnt = bus.a_req;
                        w_b_gnt = bus.b_req;
                    end
                end
            endcase
        end
    end

    assign w_gnt       = w_a_gnt | w_b_gnt;
    assign w_gnt_port  = w_b_gnt ? PORT_B : PORT_A;
    assign w_gnt_wen   = w_b_gnt ? bus.b_wen   : bus.a_wen;
    assign w_gnt_lock  = w_b_gnt ? bus.b_lock  : bus.a_lock;
    assign w_gnt_addr  = w_b_gnt ? bus.b_addr  : bus.a_addr;
    assign w_gnt_wdata = w_b_gnt ? bus.b_wdata : bus.a_wdata;

    assign w_owner      = (r_state == ST_OWN_B) ? PORT_B : PORT_A;
    assign w_owner_req  = (w_owner == PORT_B) ? bus.b_req  : bus.a_req;
    assign w_owner_lock = (w_owner == PORT_B) ? bus.b_lock : bus.a_lock;

    // ------------------------------------------------------------------
    // Ownership / round-robin state update
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_last_nxt     = r_last;
        w_lock_cnt_nxt = r_lock_cnt;
        case (r_state)
            ST_OWN_A, ST_OWN_B: begin
                if (!w_owner_req) begin
                    // Owner went away: release, and give the other port the next tie
                    w_state_nxt    = ST_IDLE;
                    w_last_nxt     = w_owner;
                    w_lock_cnt_nxt = 8'd0;
                end else if (w_gnt) begin
                    w_last_nxt = w_owner;
                    // Stay only if the owner still locks and has not used up
                    // its MAX_LOCK consecutive grants with this beat.
                    if (w_owner_lock && (int'(r_lock_cnt) + 1 < MAX_LOCK)) begin
                        w_lock_cnt_nxt = r_lock_cnt + 8'd1;
                    end else begin
                        w_state_nxt    = ST_IDLE;
                        w_lock_cnt_nxt = 8'd0;
                    end
                end
            end
            default: begin
                if (w_gnt) begin
                    w_last_nxt = w_gnt_port;
                    // A lock with MAX_LOCK=1 already ends at this first grant
                    if (w_gnt_lock && (MAX_LOCK > 1)) begin
                        w_state_nxt    = (w_gnt_port == PORT_B) ? ST_OWN_B : ST_OWN_A;
                        w_lock_cnt_nxt = 8'd1;
                    end
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Read-return pipeline (1 deep, matches the memory's read latency)
    // ------------------------------------------------------------------
    assign w_a_rvalid = r_rv_valid && (r_rv_port == PORT_A);
    assign w_b_rvalid = r_rv_valid && (r_rv_port == PORT_B);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_last      <= PORT_B;
            r_lock_cnt  <= 8'd0;
            r_init_cnt  <= 2'd0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rv_valid  <= 1'b0;
            r_rv_port   <= PORT_A;
            r_a_rdata   <= '0;
            r_b_rdata   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so every
            // register here samples the values from before this edge.
            r_state    <= w_state_nxt;
            r_last     <= w_last_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
            if (r_init_cnt != INIT_EDGES) begin
                r_init_cnt <= r_init_cnt + 2'd1;
            end
            if (w_gnt) begin
                r_mem_addr  <= w_gnt_addr;
                r_mem_wdata <= w_gnt_wdata;
            end
            r_rv_valid <= w_gnt && !w_gnt_wen;
            r_rv_port  <= w_gnt_port;
            if (w_a_rvalid) r_a_rdata <= bus.mem_rdata;
            if (w_b_rvalid) r_b_rdata <= bus.mem_rdata;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.a_gnt     = w_a_gnt;
    assign bus.b_gnt     = w_b_gnt;
    assign bus.a_rvalid  = w_a_rvalid;
    assign bus.b_rvalid  = w_b_rvalid;
    // Data passes straight through in the valid cycle and is held afterwards
    assign bus.a_rdata   = w_a_rvalid ? bus.mem_rdata : r_a_rdata;
    assign bus.b_rdata   = w_b_rvalid ? bus.mem_rdata : r_b_rdata;

    assign bus.mem_rst   = w_mem_rst;
    assign bus.mem_wen   = w_gnt && w_gnt_wen;
    assign bus.mem_addr  = w_gnt ? w_gnt_addr  : r_mem_addr;
    assign bus.mem_wdata = w_gnt ? w_gnt_wdata : r_mem_wdata;

`ifdef DMEM_ARB_STATS_EN
    // ------------------------------------------------------------------
    // Grant statistics
    // ------------------------------------------------------------------
    logic [15:0] r_a_cnt;
    logic [15:0] r_b_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a_cnt <= 16'd0;
            r_b_cnt <= 16'd0;
        end else if (clr_stats) begin
            r_a_cnt <= 16'd0;
            r_b_cnt <= 16'd0;
        end else begin
            if (w_a_gnt && (r_a_cnt != 16'hFFFF)) r_a_cnt <= r_a_cnt + 16'd1;
            if (w_b_gnt && (r_b_cnt != 16'hFFFF)) r_b_cnt <= r_b_cnt + 16'd1;
        end
    end

    assign a_cnt = r_a_cnt;
    assign b_cnt = r_b_cnt;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//   Directed bench for dmem_arbiter with a small behavioural memory
//   (256 words, registered read address, image loaded while mem_rst=1).
//   Covers the reset/init sequence, read return, round-robin, lock with
//   forced release, write-then-read and reset during a read. The grant
//   counters are covered when DMEM_ARB_STATS_EN is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_dmem_arbiter;

    logic clk;
    logic rst;
`ifdef DMEM_ARB_STATS_EN
    logic        clr_stats;
    logic [15:0] a_cnt;
    logic [15:0] b_cnt;
`endif

    dmem_arbiter_if #(.AW(16), .DW(16)) bus ();

    dmem_arbiter #(.AW(16), .DW(16), .MAX_LOCK(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus)
`ifdef DMEM_ARB_STATS_EN
        ,
        .clr_stats (clr_stats),
        .a_cnt     (a_cnt),
        .b_cnt     (b_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Memory model: image word i = 16'hA500 | i, except word 4 = 16'h1234
    // ------------------------------------------------------------------
    logic [15:0] mem [256];
    logic [7:0]  mem_raddr;

    always @(posedge clk) begin
        if (bus.mem_rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= (i == 4) ? 16'h1234 : (16'hA500 | 16'(i));
        end else if (bus.mem_wen) begin
            mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
        end
        mem_raddr <= bus.mem_addr[7:0];
    end
    assign bus.mem_rdata = mem[mem_raddr];

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.a_req = 0; bus.a_wen = 0; bus.a_lock = 0; bus.a_addr = '0; bus.a_wdata = '0;
        bus.b_req = 0; bus.b_wen = 0; bus.b_lock = 0; bus.b_addr = '0; bus.b_wdata = '0;
    endtask

    // ------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic        a_req, a_wen, a_lock;
        logic [15:0] a_addr, a_wdata;
        logic        b_req, b_wen, b_lock;
        logic [15:0] b_addr, b_wdata;
        logic        e_a_gnt, e_b_gnt, e_wen;
        logic [15:0] e_addr, e_wdata;
    } vec_t;

    function automatic vec_t mk(
        input logic ar, aw, al, input logic [15:0] aa, ad,
        input logic br, bw, bl, input logic [15:0] ba, bd,
        input logic ea, eb, ew, input logic [15:0] ex, ed);
        vec_t v;
        v.a_req = ar; v.a_wen = aw; v.a_lock = al; v.a_addr = aa; v.a_wdata = ad;
        v.b_req = br; v.b_wen = bw; v.b_lock = bl; v.b_addr = ba; v.b_wdata = bd;
        v.e_a_gnt = ea; v.e_b_gnt = eb; v.e_wen = ew; v.e_addr = ex; v.e_wdata = ed;
        return v;
    endfunction

    localparam int NVEC = 23;
    vec_t vecs [NVEC];

    initial begin
        // B alone writes: establishes last=B
        vecs[0] = mk(0,0,0,16'h0000,16'h0000, 1,1,0,16'h0020,16'hBEEF, 0,1,1,16'h0020,16'hBEEF);
        // Both request, no lock: A (write) and B (read) alternate starting with A
        for (int i = 1; i <= 6; i++) begin
            logic odd;
            odd = (i % 2) == 1;
            vecs[i] = mk(1,1,0,16'h0030,16'h5555, 1,0,0,16'h0031,16'h0000,
                         odd, !odd, odd, odd ? 16'h0030 : 16'h0031, odd ? 16'h5555 : 16'h0000);
        end
        // Nobody requests: no grant, address/data hold B's last beat
        vecs[7] = mk(0,0,0,16'h0000,16'h0000, 0,0,0,16'h0000,16'h0000, 0,0,0,16'h0031,16'h0000);
        // A alone reads: establishes last=A
        vecs[8] = mk(1,0,0,16'h0050,16'h0000, 0,0,0,16'h0000,16'h0000, 1,0,0,16'h0050,16'h0000);
        // B locks while A keeps requesting: 8 B grants, forced release, A, B re-acquires
        for (int i = 9; i <= 20; i++) begin
            logic ga;
            ga = (i == 17);
            vecs[i] = mk(1,0,0,16'h0050,16'h0000, 1,0,1,16'h0040,16'h0000,
                         ga, !ga, 0, ga ? 16'h0050 : 16'h0040, 16'h0000);
        end
        // Owner B drops req: release cycle with no grant, A stays blocked
        vecs[21] = mk(1,0,0,16'h0050,16'h0000, 0,0,1,16'h0040,16'h0000, 0,0,0,16'h0040,16'h0000);
        // Back in IDLE: A granted
        vecs[22] = mk(1,0,0,16'h0050,16'h0000, 0,0,0,16'h0040,16'h0000, 1,0,0,16'h0050,16'h0000);
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        rst = 1'b0;
        idle_inputs();
`ifdef DMEM_ARB_STATS_EN
        clr_stats = 1'b0;
`endif
        // A requests a read of 0x0004 throughout reset and init
        bus.a_req  = 1;
        bus.a_addr = 16'h0004;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_rst",   bus.mem_rst,   1);
        check("rst_a_gnt",     bus.a_gnt,     0);
        check("rst_b_gnt",     bus.b_gnt,     0);
        check("rst_a_rvalid",  bus.a_rvalid,  0);
        check("rst_b_rvalid",  bus.b_rvalid,  0);
        check("rst_mem_wen",   bus.mem_wen,   0);
        check("rst_mem_addr",  bus.mem_addr,  0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
`ifdef DMEM_ARB_STATS_EN
        check("rst_a_cnt", a_cnt, 0);
        check("rst_b_cnt", b_cnt, 0);
`endif
        // Release mid-cycle: cycle 1 runs until the next edge
        rst = 1'b1;
        #1;
        check("init_c1_mem_rst", bus.mem_rst, 1);
        check("init_c1_a_gnt",   bus.a_gnt,   0);
        @(posedge clk); #1;
        check("init_c2_mem_rst", bus.mem_rst, 1);
        check("init_c2_a_gnt",   bus.a_gnt,   0);
        @(posedge clk); #1;
        check("init_c3_mem_rst",  bus.mem_rst,  0);
        check("init_c3_a_gnt",    bus.a_gnt,    1);
        check("init_c3_b_gnt",    bus.b_gnt,    0);
        check("init_c3_mem_addr", bus.mem_addr, 16'h0004);
        check("init_c3_mem_wen",  bus.mem_wen,  0);
        @(posedge clk); #1;
        bus.a_req = 0;
        @(negedge clk);
        check("rd4_a_rvalid", bus.a_rvalid, 1);
        check("rd4_a_rdata",  bus.a_rdata,  16'h1234);
        check("rd4_b_rvalid", bus.b_rvalid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rd4_hold_a_rvalid", bus.a_rvalid, 0);
        check("rd4_hold_a_rdata",  bus.a_rdata,  16'h1234);

        // Table-driven round-robin / lock sequence
        for (int i = 0; i < NVEC; i++) begin
            @(posedge clk); #1;
            bus.a_req = vecs[i].a_req; bus.a_wen = vecs[i].a_wen; bus.a_lock = vecs[i].a_lock;
            bus.a_addr = vecs[i].a_addr; bus.a_wdata = vecs[i].a_wdata;
            bus.b_req = vecs[i].b_req; bus.b_wen = vecs[i].b_wen; bus.b_lock = vecs[i].b_lock;
            bus.b_addr = vecs[i].b_addr; bus.b_wdata = vecs[i].b_wdata;
            @(negedge clk);
            check($sformatf("v%0d_a_gnt", i),     bus.a_gnt,     vecs[i].e_a_gnt);
            check($sformatf("v%0d_b_gnt", i),     bus.b_gnt,     vecs[i].e_b_gnt);
            check($sformatf("v%0d_mem_wen", i),   bus.mem_wen,   vecs[i].e_wen);
            check($sformatf("v%0d_mem_addr", i),  bus.mem_addr,  vecs[i].e_addr);
            check($sformatf("v%0d_mem_wdata", i), bus.mem_wdata, vecs[i].e_wdata);
        end

        // Write 0x00AA to 0x0010 then read it back on the next cycle
        @(posedge clk); #1;
        idle_inputs();
        bus.a_req = 1; bus.a_wen = 1; bus.a_addr = 16'h0010; bus.a_wdata = 16'h00AA;
        @(negedge clk);
        check("wr_a_gnt",   bus.a_gnt,   1);
        check("wr_mem_wen", bus.mem_wen, 1);
        @(posedge clk); #1;
        bus.a_wen = 0;
        @(negedge clk);
        check("rd_a_gnt",   bus.a_gnt,   1);
        check("rd_mem_wen", bus.mem_wen, 0);
        @(posedge clk); #1;
        bus.a_req = 0;
        @(negedge clk);
        check("wr_rd_a_rvalid", bus.a_rvalid, 1);
        check("wr_rd_a_rdata",  bus.a_rdata,  16'h00AA);

        // Reset dropped while a read return is pending
        @(posedge clk); #1;
        bus.a_req = 1;
        @(negedge clk);
        check("mid_a_gnt", bus.a_gnt, 1);
        @(posedge clk); #1;
        bus.a_req = 0;
        #1;
        check("mid_pre_a_rvalid", bus.a_rvalid, 1);
        rst = 1'b0;
        #1;
        check("mid_a_rvalid",  bus.a_rvalid, 0);
        check("mid_mem_rst",   bus.mem_rst,  1);
        bus.a_req = 1; bus.a_wen = 1;
        @(negedge clk);
        check("mid_a_gnt_blocked", bus.a_gnt,   0);
        check("mid_mem_wen",       bus.mem_wen, 0);
        @(posedge clk); #1;
        check("mid_edge_mem_wen",  bus.mem_wen,  0);
        check("mid_edge_mem_addr", bus.mem_addr, 0);
        idle_inputs();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rel2_mem_rst", bus.mem_rst, 0);

        // Grant-count sequence: 5 A grants, then 3 B grants
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            idle_inputs();
            bus.a_req = 1;
            @(negedge clk);
            check($sformatf("st_a%0d_gnt", i), bus.a_gnt, 1);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            idle_inputs();
            bus.b_req = 1;
            @(negedge clk);
            check($sformatf("st_b%0d_gnt", i), bus.b_gnt, 1);
        end
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
`ifdef DMEM_ARB_STATS_EN
        check("st_a_cnt", a_cnt, 5);
        check("st_b_cnt", b_cnt, 3);
`endif
        // Clear coinciding with a grant: the clear wins
        @(posedge clk); #1;
        bus.a_req = 1;
`ifdef DMEM_ARB_STATS_EN
        clr_stats = 1'b1;
`endif
        @(negedge clk);
        check("clr_a_gnt", bus.a_gnt, 1);
        @(posedge clk); #1;
        idle_inputs();
`ifdef DMEM_ARB_STATS_EN
        clr_stats = 1'b0;
`endif
        @(negedge clk);
`ifdef DMEM_ARB_STATS_EN
        check("clr_a_cnt", a_cnt, 0);
        check("clr_b_cnt", b_cnt, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares one single-port data memory (one-cycle registered read address, active-high synchronous reset that loads the memory image) between two requesters. Port A is the core load/store unit; port B is the debug/DMA loader. Arbitration is round-robin, with an optional lock for multi-beat transfers. The block also returns read-data valid strobes and sequences the memory's reset/image-load.

Parameters:
AW, `ISIZE, address width
DW, `DSIZE, data width
MAX_LOCK, 8, maximum consecutive locked grants before forced release (1..255)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
a_req  in  1  port A request
a_wen  in  1  port A write (1) / read (0)
a_lock  in  1  port A holds grant after current beat
a_addr  in  AW  port A address
a_wdata  in  DW  port A write data
a_gnt  out  1  port A granted this cycle
a_rvalid  out  1  port A read data valid
a_rdata  out  DW  port A read data
b_req, b_wen, b_lock, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata  same as port A, for port B
mem_rst  out  1  active-high reset to memory
mem_wen  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data (valid the cycle after the address)

Behaviour:
- Reset (rst=0, async): state=IDLE, last=B (A wins the first tie), lock_cnt=0, all gnt/rvalid=0, mem_wen=0, mem_addr=0, mem_wdata=0, mem_rst=1.
- mem_rst stays 1 while rst=0 and for 2 clk edges after rst deasserts (gives the memory two rising edges with reset high so it loads its image), then 0. gnt is forced 0 while mem_rst=1.
- Grant is combinational from req and registered state; at most one gnt per cycle. The granted port's wen/addr/wdata go to mem_*. With no grant, mem_wen=0 and mem_addr holds its last value (registered).
- States:
  - IDLE: only one port requesting -> grant it. Both requesting -> grant the port != last.
  - OWN_A / OWN_B: the owner is granted whenever it requests; the other port is blocked.
- Transitions:
  - IDLE -> OWN_x when x is granted with x_lock=1; lock_cnt=1.
  - OWN_x -> OWN_x while x_lock=1 and lock_cnt<MAX_LOCK; lock_cnt increments on each owner grant.
  - OWN_x -> IDLE when x_lock=0 at a grant, when x_req=0, or when lock_cnt=MAX_LOCK. On release last=x, so the other port wins the next tie.
- last updates to the granted port on every grant.
- Reads: the cycle after a read grant, x_rvalid=1 and x_rdata=mem_rdata; exactly one rvalid per read grant. Write grants produce no rvalid. x_rdata holds its value when rvalid=0.
- Back-to-back reads are allowed; the rvalid pipeline is a 1-deep register of {port, is_read}.
- Write followed by read to the same address on consecutive cycles returns the new data (memory order is preserved).
- rst asserted mid-transfer: pending rvalid is dropped, lock is cleared, and no further mem_wen occurs.
- Requesters hold req/addr/wdata stable until gnt; gnt is a single-cycle acceptance.

Optional Feature:
DMEM_ARB_STATS_EN: when defined, adds outputs a_cnt and b_cnt (16 bits each) and input clr_stats.
- Each counter counts grants to its port, saturating at 0xFFFF.
- clr_stats=1 zeroes both counters on the next edge; clr_stats has priority over an increment in the same cycle.
- Both counters are 0 on reset.
When not defined, these ports and registers are absent and behaviour is otherwise identical.

Test Plan:
- Release rst; hold a_req=1 throughout -> mem_rst=1 for 2 edges after release; first a_gnt appears in cycle 3 only.
- a_req read addr 0x0004 with mem image 0x0004=0x1234 -> a_gnt=1 in cycle N; a_rvalid=1 and a_rdata=0x1234 in N+1; b_rvalid stays 0.
- a_req and b_req both held (no lock) for 6 cycles -> grants A,B,A,B,A,B; mem_wen follows the granted port's wen.
- b_lock=1 held with b_req for 12 cycles while a_req=1, MAX_LOCK=8 -> 8 consecutive b_gnt, then a_gnt, then B re-acquires.
- A writes 0x00AA to 0x0010, then reads 0x0010 next cycle -> a_rdata=0x00AA; drop rst mid-read -> a_rvalid=0 immediately and mem_rst=1.
- With DMEM_ARB_STATS_EN: 5 A grants, 3 B grants -> a_cnt=5, b_cnt=3; assert clr_stats with a concurrent grant -> both counters 0.
